// File: rtl/kvs_cmd_arbiter.sv
// Two-requester command arbiter for the KVS kernel, with in-order response routing.
// Define KVS_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module kvs_cmd_arbiter #(
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               req0_valid,
  output logic                               req0_ready,
  input  logic                               req0_search,
  input  logic [127:0]                       req0_key,
  input  logic [31:0]                        req0_value,
  input  logic                               req1_valid,
  output logic                               req1_ready,
  input  logic                               req1_search,
  input  logic [127:0]                       req1_key,
  input  logic [31:0]                        req1_value,
  output logic                               cmd_valid,
  output logic                               cmd_search,
  output logic                               cmd_update,
  output logic [127:0]                       cmd_key,
  output logic [31:0]                        cmd_value,
  input  logic                               cam_ready,
  input  logic                               cmd_full,
  input  logic                               ack,
  input  logic                               ack_hit,
  input  logic [15:0]                        ack_addr,
  input  logic [31:0]                        ack_value,
  output logic                               rsp0_valid,
  output logic                               rsp0_hit,
  output logic [15:0]                        rsp0_addr,
  output logic [31:0]                        rsp0_value,
  output logic                               rsp1_valid,
  output logic                               rsp1_hit,
  output logic [15:0]                        rsp1_addr,
  output logic [31:0]                        rsp1_value,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               orphan_err
);

  localparam int AW = $clog2(MAX_OUTSTANDING);
  localparam logic [AW:0] MAX_CNT = (AW+1)'(MAX_OUTSTANDING);
  localparam logic [AW:0] ONE     = (AW+1)'(1);

  logic          can_issue;
  logic          pref1;
  logic          grant0;
  logic          grant1;
  logic          accept;
  logic          accept_id;
  logic          pop;
  logic          pop_tag;
  logic          tag_mem [MAX_OUTSTANDING];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // can_issue looks only at the registered count, so an ack never frees a slot in its own cycle
  assign can_issue = cam_ready & ~cmd_full & (outstanding < MAX_CNT);

`ifdef KVS_ARB_FIXED_PRIO_EN
  assign pref1 = 1'b0;
`else
  logic last_grant;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= accept_id;
    end
  end

  assign pref1 = ~last_grant;
`endif

  assign grant0     = req0_valid & (~req1_valid | ~pref1);
  assign grant1     = req1_valid & ~grant0;
  assign req0_ready = grant0 & can_issue;
  assign req1_ready = grant1 & can_issue;
  assign accept     = (grant0 | grant1) & can_issue;
  assign accept_id  = grant1;

  assign pop     = ack & (outstanding != '0);
  assign pop_tag = tag_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (accept) begin
      tag_mem[wr_ptr] <= accept_id;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      orphan_err  <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + ONE;
        2'b01:   outstanding <= outstanding - ONE;
        default: outstanding <= outstanding;
      endcase
      if (ack && outstanding == '0) begin
        orphan_err <= 1'b1;
      end
    end
  end

  // Command stage: one-cycle pulse per acceptance, fields hold between pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_valid  <= 1'b0;
      cmd_search <= 1'b0;
      cmd_update <= 1'b0;
      cmd_key    <= '0;
      cmd_value  <= '0;
    end else begin
      cmd_valid <= accept;
      if (accept) begin
        cmd_search <= accept_id ? req1_search : req0_search;
        cmd_update <= accept_id ? ~req1_search : ~req0_search;
        cmd_key    <= accept_id ? req1_key : req0_key;
        cmd_value  <= accept_id ? req1_value : req0_value;
      end
    end
  end

  // Response stage: route the ack to the requester at the head of the tag FIFO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp0_valid <= 1'b0;
      rsp0_hit   <= 1'b0;
      rsp0_addr  <= '0;
      rsp0_value <= '0;
      rsp1_valid <= 1'b0;
      rsp1_hit   <= 1'b0;
      rsp1_addr  <= '0;
      rsp1_value <= '0;
    end else begin
      rsp0_valid <= pop & ~pop_tag;
      rsp1_valid <= pop & pop_tag;
      if (pop && !pop_tag) begin
        rsp0_hit   <= ack_hit;
        rsp0_addr  <= ack_addr;
        rsp0_value <= ack_value;
      end
      if (pop && pop_tag) begin
        rsp1_hit   <= ack_hit;
        rsp1_addr  <= ack_addr;
        rsp1_value <= ack_value;
      end
    end
  end

endmodule

// File: doc/kvs_cmd_arbiter.md
KVS_CMD_ARBITER -- requirements
Module: kvs_cmd_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_OUTSTANDING, default 8, meaning the maximum number of commands issued to the KVS kernel and not yet acknowledged (power of two, 2..64).
REQ-002 The block SHALL have the port clk, input, 1, the single clock for all logic.
REQ-003 The block SHALL have the port reset_n, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have the ports reqN_valid (input, 1), reqN_ready (output, 1), reqN_search (input, 1; 1=search, 0=update), reqN_key (input, 128) and reqN_value (input, 32) for each requester N=0,1.
REQ-005 The block SHALL have the ports cmd_valid, cmd_search and cmd_update (outputs, 1 each), cmd_key (output, 128) and cmd_value (output, 32) driving the KVS kernel command port.
REQ-006 The block SHALL have the ports cam_ready (input, 1; kernel O_READY) and cmd_full (input, 1; kernel O_CMD_FULL).
REQ-007 The block SHALL have the ports ack (input, 1), ack_hit (input, 1; single or multi hit), ack_addr (input, 16) and ack_value (input, 32) carrying kernel responses.
REQ-008 The block SHALL have the ports rspN_valid and rspN_hit (outputs, 1 each), rspN_addr (output, 16) and rspN_value (output, 32) for each requester N=0,1.
REQ-009 The block SHALL have the ports outstanding (output, clog2(MAX_OUTSTANDING)+1; in-flight count) and orphan_err (output, 1; sticky error flag).

Function
REQ-010 can_issue SHALL be the condition cam_ready=1, cmd_full=0 and outstanding<MAX_OUTSTANDING.
REQ-011 At most one request SHALL be granted per cycle; reqN_ready SHALL be combinational, equal to grantN AND can_issue, and a request SHALL be accepted when reqN_valid and reqN_ready are both 1.
REQ-012 With one requester valid, that requester SHALL be granted; with both valid, the requester not granted at the most recent acceptance SHALL be granted; last_grant SHALL update only on acceptance.
REQ-013 An acceptance at edge E SHALL drive cmd_valid=1 for exactly the cycle after E, with cmd_search=reqN_search, cmd_update=~reqN_search, and cmd_key/cmd_value registered from the accepted requester.
REQ-014 cmd_valid SHALL otherwise be 0; cmd_key, cmd_value, cmd_search and cmd_update SHALL hold their last values while cmd_valid=0.
REQ-015 Each acceptance SHALL push the 1-bit requester id into an in-order tag FIFO of depth MAX_OUTSTANDING.
REQ-016 On ack=1 with the tag FIFO non-empty, the block SHALL pop one tag and, in the next cycle, drive rspT_valid=1 for one cycle with rspT_hit/addr/value registered from ack_hit/ack_addr/ack_value, where T is the popped tag.
REQ-017 The response to the other requester SHALL have rsp_valid=0 in that cycle; responses have no backpressure and SHALL never be dropped.
REQ-018 outstanding SHALL increment on acceptance, decrement on a popping ack, and remain unchanged when both occur in the same cycle.
REQ-019 An ack with the tag FIFO empty SHALL produce no rsp_valid, leave outstanding at 0 and set orphan_err=1 until reset.
REQ-020 When outstanding=MAX_OUTSTANDING, both ready outputs SHALL be 0; a same-cycle ack SHALL NOT enable issue in that cycle, because can_issue uses the registered count.
REQ-021 cam_ready=0 or cmd_full=1 SHALL block acceptance without affecting in-flight responses.

Reset
REQ-022 While reset_n=0, cmd_valid, cmd_search, cmd_update, cmd_key, cmd_value, every rspN_* output, outstanding and orphan_err SHALL be 0, the tag FIFO SHALL be empty and last_grant SHALL be 1, so requester 0 wins first.
REQ-023 Reset asserted mid-operation SHALL discard all in-flight tags; acks arriving after reset release SHALL be treated as orphans per REQ-019.

Configuration
REQ-024 With macro KVS_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win when both requesters are valid, and last_grant SHALL be unused.
REQ-025 Without KVS_ARB_FIXED_PRIO_EN, the block SHALL use round-robin arbitration per REQ-012.

Verification
REQ-026 Test: both requesters continuously valid, cam_ready=1, acks 3 cycles after each cmd -> grants alternate 0,1,0,1 and rsp0/rsp1 each receive their own acks in order.
REQ-027 Test: requester 0 issues 8 searches with no ack (MAX_OUTSTANDING=8) -> outstanding=8 and req0_ready=0; one ack returns -> outstanding=7 and ready reasserts the following cycle.
REQ-028 Test: acceptance and ack in the same cycle at outstanding=3 -> outstanding stays 3, one cmd_valid pulse and one rsp pulse.
REQ-029 Test: ack=1 with ack_hit=1, ack_addr=16'h0042, ack_value=32'h5 after a req1 update -> next cycle rsp1_valid=1, rsp1_hit=1, rsp1_addr=16'h0042, rsp1_value=32'h5, and rsp0_valid=0.
REQ-030 Test: ack with nothing outstanding -> orphan_err=1, no rsp_valid, outstanding=0; reset_n pulse -> orphan_err=0.
REQ-031 Test: with KVS_ARB_FIXED_PRIO_EN defined and both requesters valid for 4 cycles -> four grants to requester 0 and req1_ready=0 throughout.
